// File: rtl/gpio_bank_arbiter.sv
// gpio_bank_arbiter
// Shares one user I/O bank between NUM_REQ requesters. Ownership is granted
// round-robin with a bounded hold time. A tri-state turnaround of TURN_CYC
// cycles separates consecutive owners so two drivers never overlap on the pads.
// Optional feature macro: GPIO_ARB_PRIO0_EN (requester 0 becomes high priority).
module gpio_bank_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 255,
  parameter int TURN_CYC = 1
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*DATA_W-1:0] req_oeb,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         io_out,
  output logic [DATA_W-1:0]         io_oeb,
  output logic                      busy,
  output logic                      preempt
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam int TURN_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD - 1);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYC - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_TURN
  } state_t;

  state_t              state_q,    state_d;
  logic [NUM_REQ-1:0]  gnt_q,      gnt_d;
  logic [IDX_W-1:0]    owner_q,    owner_d;
  logic [IDX_W-1:0]    last_idx_q, last_idx_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [TURN_W-1:0]   turn_cnt_q, turn_cnt_d;
  logic [DATA_W-1:0]   io_out_q,   io_out_d;
  logic [DATA_W-1:0]   io_oeb_q,   io_oeb_d;
  logic                preempt_q,  preempt_d;

  // Per-requester views of the flattened data / enable buses.
  logic [DATA_W-1:0] data_arr [NUM_REQ];
  logic [DATA_W-1:0] oeb_arr  [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
      assign oeb_arr[gi]  = req_oeb[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic             others_wait;
  logic             force_rel;

  // Arbiter: first set request after last_idx, wrapping; descending loop so
  // the closest candidate is the one left standing.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand      = '0;
    win_found = |req;
    win_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_idx_q) + k) % NUM_REQ);
      if (req[cand]) begin
        win_idx = cand;
      end
    end
`ifdef GPIO_ARB_PRIO0_EN
    if (req[0]) begin
      win_idx = '0;
    end
`endif
  end

  // Forced-release decision for the current owner.
  always_comb begin
    others_wait = |(req & ~gnt_q);
`ifdef GPIO_ARB_PRIO0_EN
    force_rel = (owner_q != '0) &&
                (((hold_cnt_q == HOLD_MAX) && others_wait) ||
                 ((hold_cnt_q != '0) && req[0]));
`else
    force_rel = (hold_cnt_q == HOLD_MAX) && others_wait;
`endif
  end

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    last_idx_d = last_idx_q;
    hold_cnt_d = hold_cnt_q;
    turn_cnt_d = turn_cnt_q;
    io_out_d   = io_out_q;
    io_oeb_d   = io_oeb_q;
    preempt_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d    = ST_GRANT;
          gnt_d      = NUM_REQ'(1) << win_idx;
          owner_d    = win_idx;
          hold_cnt_d = '0;
`ifdef GPIO_ARB_PRIO0_EN
          if (win_idx != '0) last_idx_d = win_idx;
`else
          last_idx_d = win_idx;
`endif
        end
      end

      ST_GRANT: begin
        // Pads follow the owner with one cycle of latency.
        io_out_d = data_arr[owner_q];
        io_oeb_d = oeb_arr[owner_q];
        if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
        // Voluntary release takes precedence over a forced one.
        if (!req[owner_q] || force_rel) begin
          state_d    = ST_TURN;
          gnt_d      = '0;
          io_oeb_d   = '1;
          hold_cnt_d = '0;
          turn_cnt_d = '0;
          preempt_d  = req[owner_q];
        end
      end

      ST_TURN: begin
        if (turn_cnt_q == TURN_LAST) begin
          if (win_found) begin
            state_d    = ST_GRANT;
            gnt_d      = NUM_REQ'(1) << win_idx;
            owner_d    = win_idx;
            hold_cnt_d = '0;
`ifdef GPIO_ARB_PRIO0_EN
            if (win_idx != '0) last_idx_d = win_idx;
`else
            last_idx_d = win_idx;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          turn_cnt_d = turn_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        gnt_d    = '0;
        io_oeb_d = '1;
      end
    endcase
  end

  // State register; reset releases the pads immediately.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      last_idx_q <= IDX_LAST;
      hold_cnt_q <= '0;
      turn_cnt_q <= '0;
      io_out_q   <= '0;
      io_oeb_q   <= '1;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      last_idx_q <= last_idx_d;
      hold_cnt_q <= hold_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      io_out_q   <= io_out_d;
      io_oeb_q   <= io_oeb_d;
      preempt_q  <= preempt_d;
    end
  end

  assign gnt     = gnt_q;
  assign io_out  = io_out_q;
  assign io_oeb  = io_oeb_q;
  assign busy    = (state_q != ST_IDLE);
  assign preempt = preempt_q;

endmodule
